// File: rtl/pipeline_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// IDLE/ACCESS FSM; grant and strobes in ACCESS, done/err/rdata one cycle later.
module pipeline_mem_arbiter #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_we0,
  input  logic             i_we1,
  input  logic [31:0]      i_addr0,
  input  logic [31:0]      i_addr1,
  input  logic [31:0]      i_wdata0,
  input  logic [31:0]      i_wdata1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic             o_err0,
  output logic             o_err1,
  output logic [31:0]      o_rdata0,
  output logic [31:0]      o_rdata1,
  output logic             o_MemWrite,
  output logic             o_MemRead,
  output logic [31:0]      o_address,
  output logic [31:0]      o_data,
  input  logic [31:0]      i_mem_data,
  output logic [CNT_W-1:0] o_conflicts
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [31:0]      DEPTH_W = 32'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               err0_q, err0_d;
  logic               err1_q, err1_d;
  logic [31:0]        rdata0_q, rdata0_d;
  logic [31:0]        rdata1_q, rdata1_d;
  logic [CNT_W-1:0]   conf_q, conf_d;

  logic acc;
  logic in_range;
  logic pick0;
  logic rd_val_sel;
  logic [31:0] rd_val;

  assign acc      = (state_q == ACCESS);
  assign in_range = (addr_q < DEPTH_W);
  assign pick0    = i_req0 & (~i_req1 | last_q);
  assign rd_val_sel = in_range;
  assign rd_val   = rd_val_sel ? i_mem_data : 32'h0;

  // Next-state: arbitration, request latching, completion and counter.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    conf_d   = conf_q;
    unique case (state_q)
      IDLE: begin
        if (i_req0 & i_req1 & (conf_q != CNT_MAX)) begin
          conf_d = conf_q + 1'b1;
        end
        if (i_req0 | i_req1) begin
          state_d = ACCESS;
          id_d    = ~pick0;
          last_d  = ~pick0;
          we_d    = pick0 ? i_we0 : i_we1;
          addr_d  = pick0 ? i_addr0 : i_addr1;
          wdata_d = pick0 ? i_wdata0 : i_wdata1;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        done0_d = ~id_q;
        done1_d = id_q;
        err0_d  = ~id_q & ~in_range;
        err1_d  = id_q & ~in_range;
        if (!we_q) begin
          if (id_q) rdata1_d = rd_val;
          else      rdata0_d = rd_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      conf_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      conf_q   <= conf_d;
    end
  end

  // Memory-side and grant outputs decode straight from the ACCESS state.
  always_comb begin
    o_gnt0     = acc & ~id_q;
    o_gnt1     = acc & id_q;
    o_MemWrite = acc & in_range & we_q;
    o_MemRead  = acc & in_range & ~we_q;
    o_address  = acc ? addr_q : 32'h0;
    o_data     = acc ? wdata_q : 32'h0;
  end

  assign o_done0     = done0_q;
  assign o_done1     = done1_q;
  assign o_err0      = err0_q;
  assign o_err1      = err1_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_conflicts = conf_q;

endmodule

// File: doc/pipeline_mem_arbiter.md
PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of valid memory words; word addresses 0..DEPTH-1 are legal.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the conflict counter.
REQ-003 Port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports i_req0/i_req1, input, 1 each: requester k access request, held until granted.
REQ-006 Ports i_we0/i_we1, input, 1 each: 1 = write, 0 = read.
REQ-007 Ports i_addr0/i_addr1, input, 32 each: word address.
REQ-008 Ports i_wdata0/i_wdata1, input, 32 each: write data.
REQ-009 Ports o_gnt0/o_gnt1, output, 1 each: one-cycle grant pulse.
REQ-010 Ports o_done0/o_done1, output, 1 each: one-cycle completion pulse.
REQ-011 Ports o_err0/o_err1, output, 1 each: out-of-range pulse, coincident with o_doneK.
REQ-012 Ports o_rdata0/o_rdata1, output, 32 each: registered read data.
REQ-013 Port o_MemWrite, output, 1: memory write strobe.
REQ-014 Port o_MemRead, output, 1: memory read enable.
REQ-015 Port o_address, output, 32: memory address.
REQ-016 Port o_data, output, 32: memory write data.
REQ-017 Port i_mem_data, input, 32: combinational memory read data.
REQ-018 Port o_conflicts, output, CNT_W: saturating count of cycles in IDLE with both requests active.

Function
REQ-019 FSM states SHALL be IDLE and ACCESS only.
REQ-020 In IDLE with any i_reqK=1, the FSM SHALL latch that requester's id, we, addr and wdata and go to ACCESS on the next edge; with no request it SHALL stay in IDLE.
REQ-021 When both requests are active in IDLE, the winner SHALL be the port not granted last (round-robin); after reset, port 0 wins first.
REQ-022 ACCESS SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 In ACCESS, o_gntK SHALL be 1 for the latched port only, and o_address/o_data SHALL carry the latched addr/wdata.
REQ-024 In ACCESS with addr < DEPTH, o_MemWrite SHALL equal latched we and o_MemRead SHALL equal the inverse of latched we.
REQ-025 In ACCESS with addr >= DEPTH, both memory strobes SHALL be 0.
REQ-026 Outside ACCESS, o_MemWrite, o_MemRead, o_address and o_data SHALL be 0.
REQ-027 On the edge ending ACCESS, o_rdataK SHALL capture i_mem_data for a legal read, 0 for an illegal read, and stay unchanged for a write.
REQ-028 In the cycle after ACCESS, o_doneK SHALL pulse for one cycle, and o_errK SHALL pulse with it when addr >= DEPTH.
REQ-029 Latency SHALL be: request seen in IDLE at cycle T, grant and strobes at T+1, done and data at T+2.
REQ-030 Throughput SHALL be at most one access every 2 cycles; an IDLE at T+2 may start the next access.
REQ-031 Requesters SHALL drop i_reqK in the cycle after seeing o_gntK; a request still held at that time SHALL be treated as a new request.
REQ-032 Requests changing while in ACCESS SHALL be ignored until IDLE.
REQ-033 o_conflicts SHALL increment by 1 in each IDLE cycle with i_req0=i_req1=1, and SHALL saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-034 When i_rst_n=0, the block SHALL immediately and asynchronously force IDLE, last-granted = port 1, every output to 0 (including o_rdataK and o_conflicts), and both memory strobes to 0.
REQ-035 A reset asserted during ACCESS SHALL abort the access; no done or err pulse SHALL follow, and any write strobe SHALL be removed immediately.
REQ-036 Operation SHALL resume on the first rising edge after i_rst_n returns to 1.

Verification
REQ-037 Single write then read: port0 write addr 5, data 0xDEADBEEF; then port0 read addr 5 -> o_MemWrite=1 for one cycle at T+1, o_done0 at T+2; the read gives o_rdata0=0xDEADBEEF at its own T+2.
REQ-038 Simultaneous requests after reset: req0 and req1 both held -> grants in order 0, 1, 0, 1 every 2 cycles, and o_conflicts increments per contested IDLE cycle.
REQ-039 Out of range: port1 read addr 32 -> no strobes, o_done1=o_err1=1 at T+2, o_rdata1=0.
REQ-040 Reset mid-access: assert i_rst_n=0 during a port0 write ACCESS -> o_MemWrite drops immediately, no o_done0, and after release port 0 wins the first contest.
REQ-041 Saturation: with CNT_W=2, hold both requests for 10 IDLE cycles -> o_conflicts stays at 3.
REQ-042 Held request: req0 kept high through o_gnt0 -> a second access begins at T+3 with o_gnt0 again.
